clk_div_multi: RTL and testbench

CLK_DIV_MULTI -- requirements
Module: clk_div_multi

---
 rtl/clk_div_multi.sv | 67 ++++++
 tb/tb_clk_div_multi.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/clk_div_multi.sv
// clk_div_multi: independent programmable clock dividers whose shadowed configuration
// takes effect on the channel's next wrap, or at once while the channel is disabled.
module clk_div_multi #(
  parameter int CH = 4,
  parameter int CW = 25,
  parameter int DEFAULT_DIV = 25000000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] en,
  input  logic          cfg_wr,
  input  logic [3:0]    cfg_ch,
  input  logic [CW-1:0] cfg_div,
  input  logic          cfg_mode,
  output logic [CH-1:0] out_clk,
  output logic [CH-1:0] tick,
  output logic [CH-1:0] cfg_pend,
  output logic          cfg_err
);
  localparam logic [CW-1:0] DDIV = CW'(DEFAULT_DIV);
  logic acc;
  assign acc = cfg_wr && (32'(cfg_ch) < 32'(CH)) && (cfg_div != '0);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cfg_err <= 1'b0;
    else cfg_err <= cfg_wr && !acc;
  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [CW-1:0] cnt, div, sdiv;
    logic mode, smode, pend, o, t, wr, wrap;
    assign wr = acc && (cfg_ch == 4'(i));
    assign wrap = en[i] && (cnt == div - CW'(1));
    assign out_clk[i] = o;
    assign tick[i] = t;
    assign cfg_pend[i] = pend;
    // A mode change in either direction restarts the square wave from 0.
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        cnt <= '0;
        div <= DDIV;
        sdiv <= DDIV;
        mode <= 1'b0;
        smode <= 1'b0;
        pend <= 1'b0;
        o <= 1'b0;
        t <= 1'b0;
      end else begin
        if (!en[i]) begin
          cnt <= '0;
          o <= 1'b0;
          t <= 1'b0;
        end else begin
          cnt <= wrap ? '0 : cnt + CW'(1);
          t <= wrap;
          if (wrap) o <= (mode || (pend && smode)) ? 1'b0 : ~o;
        end
        if (pend && (!en[i] || wrap)) begin
          div <= sdiv;
          mode <= smode;
          pend <= 1'b0;
        end
        if (wr) begin
          sdiv <= cfg_div;
          smode <= cfg_mode;
          pend <= 1'b1;
        end
      end
  end
endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: directed and random stimulus against a time-based reference model,
// with a scoreboard queue of expected per-cycle outputs.
module tb_clk_div_multi;
  localparam int CH = 4;
  logic clk = 1'b0, rst = 1'b0, cfg_wr = 1'b0, cfg_mode = 1'b0;
  logic [3:0] en = '0, cfg_ch = '0;
  logic [7:0] cfg_div = '0;
  logic [3:0] out_clk, tick, cfg_pend;
  logic cfg_err;
  int tests = 0, fails = 0, cyc = 0;
  typedef struct packed { logic [3:0] o, t, p; logic e; } exp_t;
  typedef struct { int d; bit m; int sd; bit sm; bit p; int base; bit lvl; } ch_t;
  exp_t q[$];
  exp_t mx, mg;
  ch_t mc[CH];
  clk_div_multi #(.CH(4), .CW(8), .DEFAULT_DIV(5)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .cfg_mode(cfg_mode), .out_clk(out_clk), .tick(tick), .cfg_pend(cfg_pend), .cfg_err(cfg_err)
  );
  always #5 clk = ~clk;
  // Model: a run starts at cycle `base` with out level `lvl`; the k-th enabled edge of the
  // run wraps when k is a multiple of the divisor and out flips once per completed period.
  task automatic mreset();
    for (int i = 0; i < CH; i++) mc[i] = '{d: 5, m: 0, sd: 5, sm: 0, p: 0, base: cyc + 1, lvl: 0};
  endtask
  task automatic model_step();
    exp_t x;
    bit acc;
    x = '0;
    if (!rst) mreset();
    else begin
      acc = cfg_wr && int'(cfg_ch) < CH && cfg_div != 0;
      x.e = cfg_wr && !acc;
      for (int i = 0; i < CH; i++) begin
        bit o, t;
        int k;
        o = 0;
        t = 0;
        if (!en[i]) begin
          if (mc[i].p) begin
            mc[i].d = mc[i].sd; mc[i].m = mc[i].sm; mc[i].p = 0;
          end
          mc[i].base = cyc + 1;
          mc[i].lvl = 0;
        end else begin
          k = cyc - mc[i].base + 1;
          t = (k % mc[i].d) == 0;
          o = mc[i].m ? 1'b0 : mc[i].lvl ^ (((k / mc[i].d) % 2) == 1);
          if (t && mc[i].p) begin
            if (mc[i].m || mc[i].sm) o = 0;
            mc[i].d = mc[i].sd; mc[i].m = mc[i].sm; mc[i].p = 0;
            mc[i].base = cyc + 1;
            mc[i].lvl = o;
          end
        end
        if (acc && int'(cfg_ch) == i) begin
          mc[i].sd = int'(cfg_div); mc[i].sm = cfg_mode; mc[i].p = 1;
        end
        x.o[i] = o;
        x.t[i] = t;
        x.p[i] = mc[i].p;
      end
    end
    q.push_back(x);
  endtask
  initial forever begin
    @(negedge rst);
    mreset();
  end
  initial forever begin
    @(posedge clk);
    cyc++;
    model_step();
  end
  initial forever begin
    @(posedge clk);
    #1;
    tests++;
    if (q.size() == 0) begin
      fails++;
      $display("FAIL scoreboard_empty cycle %0d: no expected entry", cyc);
    end else begin
      mx = q.pop_front();
      mg = {out_clk, tick, cfg_pend, cfg_err};
      if (mg !== mx) begin
        fails++;
        $display("FAIL outputs cycle %0d: out_clk=%b want %b tick=%b want %b pend=%b want %b err=%b want %b",
                 cyc, mg.o, mx.o, mg.t, mx.t, mg.p, mx.p, mg.e, mx.e);
      end
    end
  end
  task automatic wr(input int c, input int d, input bit m);
    cfg_wr = 1; cfg_ch = 4'(c); cfg_div = 8'(d); cfg_mode = m;
    @(negedge clk);
    cfg_wr = 0;
  endtask
  task automatic async_rst();
    #2 rst = 0;
    #1;
    tests++;
    if ({out_clk, tick, cfg_pend, cfg_err} !== 13'd0) begin
      fails++;
      $display("FAIL async_reset got %b want 0", {out_clk, tick, cfg_pend, cfg_err});
    end
    @(negedge clk);
    rst = 1;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    rst = 1;
    en = 4'b0001;
    repeat (40) @(negedge clk);
    en = 4'b0011;
    repeat (7) @(negedge clk);
    wr(1, 3, 1);
    repeat (20) @(negedge clk);
    en = 4'b1111;
    wr(2, 0, 0);
    wr(7, 4, 0);
    repeat (12) @(negedge clk);
    begin
      int n = 0;
      while (!tick[0] && n < 20) begin
        @(negedge clk);
        n++;
      end
      tests++;
      if (!tick[0]) begin
        fails++;
        $display("FAIL tick0_wait got 0 want 1 within 20 cycles");
      end
    end
    repeat (4) @(negedge clk);
    wr(0, 2, 0);
    repeat (2) @(negedge clk);
    wr(0, 4, 0);
    repeat (25) @(negedge clk);
    en[3] = 0;
    wr(3, 1, 0);
    repeat (2) @(negedge clk);
    en[3] = 1;
    repeat (10) @(negedge clk);
    wr(0, 3, 1);
    wr(2, 6, 0);
    async_rst();
    repeat (30) @(negedge clk);
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < CH; i++) if ($urandom_range(0, 15) == 0) en[i] = ~en[i];
      cfg_wr = $urandom_range(0, 4) == 0;
      cfg_ch = 4'($urandom_range(0, 5));
      cfg_div = 8'($urandom_range(0, 6));
      cfg_mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 299) == 0) async_rst();
      else @(negedge clk);
    end
    cfg_wr = 0;
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
